// File: rtl/zx_dcmi_capture.sv
// -----------------------------------------------------------------------------
// zx_dcmi_capture
//
// Captures the ZX Spectrum RGBI pixel stream and re-emits a cropped, optionally
// decimated and optionally two-pixel-packed stream on the MCU DCMI port.
// Configuration is shadowed at every frame start, so register writes from the
// SPI block take effect on the next frame only. The exception is cfg_enable,
// which also gates the outputs live.
//
// Ports:
//   ZX_PIX_CLK   pixel clock, all logic on the rising edge
//   reset        synchronous, active-low
//   zx_pix       pixel data {I,B,G,R}, bit 0 = R
//   zx_hs/zx_vs  horizontal / vertical sync, active high
//   cfg_enable   capture enable (shadowed, and also live output gate)
//   cfg_pack     0: one pixel per word, 1: two pixels per word
//   cfg_decim    capture one frame of every cfg_decim+1
//   cfg_x0/x1    window columns [x0, x1)
//   cfg_y0/y1    window rows    [y0, y1)
//   dcmi_data    output word (holds while dcmi_valid is low)
//   dcmi_valid   word strobe
//   dcmi_href    row-in-window
//   dcmi_vsync   captured frame active (window rows only)
//   frame_cnt    number of vs rising edges, wraps
//   lines_last   line count of the previous frame
// -----------------------------------------------------------------------------
module zx_dcmi_capture #(
    parameter int PIX_W = 4,
    parameter int OUT_W = 8,
    parameter int CNT_W = 10,
    parameter int FRM_W = 16
) (
    input  logic             ZX_PIX_CLK,
    input  logic             reset,
    input  logic [PIX_W-1:0] zx_pix,
    input  logic             zx_hs,
    input  logic             zx_vs,
    input  logic             cfg_enable,
    input  logic             cfg_pack,
    input  logic [3:0]       cfg_decim,
    input  logic [CNT_W-1:0] cfg_x0,
    input  logic [CNT_W-1:0] cfg_x1,
    input  logic [CNT_W-1:0] cfg_y0,
    input  logic [CNT_W-1:0] cfg_y1,
    output logic [OUT_W-1:0] dcmi_data,
    output logic             dcmi_valid,
    output logic             dcmi_href,
    output logic             dcmi_vsync,
    output logic [FRM_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] lines_last
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Sync edge detection
    logic hs_reg;
    logic vs_reg;
    logic hs_rise;
    logic vs_rise;

    // Position counters and frame state
    logic [CNT_W-1:0] x_reg;
    logic [CNT_W-1:0] y_reg;
    logic             synced_reg;
    logic             cap_reg;
    logic [3:0]       dec_reg;
    logic [FRM_W-1:0] frame_cnt_reg;
    logic [CNT_W-1:0] lines_last_reg;

    // Shadowed configuration
    logic             en_sh_reg;
    logic             pack_sh_reg;
    logic [CNT_W-1:0] x0_sh_reg;
    logic [CNT_W-1:0] x1_sh_reg;
    logic [CNT_W-1:0] y0_sh_reg;
    logic [CNT_W-1:0] y1_sh_reg;

    // Pack buffer and output registers
    logic [PIX_W-1:0] buf_reg;
    logic [PIX_W-1:0] buf_next;
    logic             buf_full_reg;
    logic             buf_full_next;
    logic [OUT_W-1:0] data_reg;
    logic [OUT_W-1:0] data_next;
    logic             valid_reg;
    logic             valid_next;
    logic             href_reg;
    logic             href_next;
    logic             vsync_reg;
    logic             vsync_next;

    // Window decode
    logic x_in;
    logic y_in;
    logic frame_on;
    logic in_win;

    // Candidate output words
    logic [OUT_W-1:0] word_single;
    logic [OUT_W-1:0] word_pair;
    logic [OUT_W-1:0] word_flush;

    assign hs_rise = zx_hs & ~hs_reg;
    assign vs_rise = zx_vs & ~vs_reg;

    // Inverted or empty bounds simply never satisfy both comparisons.
    assign x_in     = (x_reg >= x0_sh_reg) && (x_reg < x1_sh_reg);
    assign y_in     = (y_reg >= y0_sh_reg) && (y_reg < y1_sh_reg);
    assign frame_on = synced_reg & en_sh_reg & cap_reg;
    assign in_win   = frame_on & x_in & y_in;

    // Word layouts: single = {0, pix}; pair = {0, pix, buffered}; flush = {0, buffered}.
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_word
        if (gi < PIX_W) begin : g_lo
            assign word_single[gi] = zx_pix[gi];
            assign word_pair[gi]   = buf_reg[gi];
            assign word_flush[gi]  = buf_reg[gi];
        end else if (gi < 2 * PIX_W) begin : g_mid
            assign word_single[gi] = 1'b0;
            assign word_pair[gi]   = zx_pix[gi-PIX_W];
            assign word_flush[gi]  = 1'b0;
        end else begin : g_hi
            assign word_single[gi] = 1'b0;
            assign word_pair[gi]   = 1'b0;
            assign word_flush[gi]  = 1'b0;
        end
    end

    always_comb begin
        data_next     = data_reg;
        valid_next    = 1'b0;
        href_next     = 1'b0;
        buf_next      = buf_reg;
        buf_full_next = buf_full_reg;

        if (pack_sh_reg) begin
            if (in_win) begin
                href_next = 1'b1;
                if (buf_full_reg) begin
                    data_next     = word_pair;
                    valid_next    = 1'b1;
                    buf_full_next = 1'b0;
                end else begin
                    buf_next      = zx_pix;
                    buf_full_next = 1'b1;
                end
            end else if (buf_full_reg) begin
                // Odd pixel left at window exit; href stays up for this slot.
                data_next     = word_flush;
                valid_next    = 1'b1;
                href_next     = 1'b1;
                buf_full_next = 1'b0;
            end
        end else if (in_win) begin
            data_next  = word_single;
            valid_next = 1'b1;
            href_next  = 1'b1;
        end

        // Sync edges drop anything still buffered once the flush above is done.
        if (hs_rise || vs_rise) begin
            buf_full_next = 1'b0;
        end

        vsync_next = frame_on & y_in;

        // The live enable overrides everything on the output side.
        if (!cfg_enable) begin
            data_next     = data_reg;
            valid_next    = 1'b0;
            href_next     = 1'b0;
            vsync_next    = 1'b0;
            buf_full_next = 1'b0;
        end
    end

    always_ff @(posedge ZX_PIX_CLK) begin
        if (!reset) begin
            hs_reg         <= 1'b0;
            vs_reg         <= 1'b0;
            x_reg          <= '0;
            y_reg          <= '0;
            synced_reg     <= 1'b0;
            cap_reg        <= 1'b0;
            dec_reg        <= '0;
            frame_cnt_reg  <= '0;
            lines_last_reg <= '0;
            en_sh_reg      <= 1'b0;
            pack_sh_reg    <= 1'b0;
            x0_sh_reg      <= '0;
            x1_sh_reg      <= '0;
            y0_sh_reg      <= '0;
            y1_sh_reg      <= '0;
            buf_reg        <= '0;
            buf_full_reg   <= 1'b0;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            href_reg       <= 1'b0;
            vsync_reg      <= 1'b0;
        end else begin
            hs_reg       <= zx_hs;
            vs_reg       <= zx_vs;
            buf_reg      <= buf_next;
            buf_full_reg <= buf_full_next;
            data_reg     <= data_next;
            valid_reg    <= valid_next;
            href_reg     <= href_next;
            vsync_reg    <= vsync_next;

            // vs takes priority over a coincident hs so the frame starts on row 0.
            if (vs_rise) begin
                x_reg          <= '0;
                y_reg          <= '0;
                lines_last_reg <= y_reg;
                frame_cnt_reg  <= frame_cnt_reg + FRM_W'(1);
                synced_reg     <= 1'b1;
                en_sh_reg      <= cfg_enable;
                pack_sh_reg    <= cfg_pack;
                x0_sh_reg      <= cfg_x0;
                x1_sh_reg      <= cfg_x1;
                y0_sh_reg      <= cfg_y0;
                y1_sh_reg      <= cfg_y1;
                // The reload value is the decimation just shadowed for this frame.
                cap_reg        <= (dec_reg == 4'd0);
                dec_reg        <= (dec_reg == 4'd0) ? cfg_decim : dec_reg - 4'd1;
            end else if (hs_rise) begin
                x_reg <= '0;
                if (y_reg != CNT_MAX) begin
                    y_reg <= y_reg + CNT_W'(1);
                end
            end else if (x_reg != CNT_MAX) begin
                x_reg <= x_reg + CNT_W'(1);
            end
        end
    end

    assign dcmi_data  = data_reg;
    assign dcmi_valid = valid_reg;
    assign dcmi_href  = href_reg;
    assign dcmi_vsync = vsync_reg;
    assign frame_cnt  = frame_cnt_reg;
    assign lines_last = lines_last_reg;

endmodule

// File: tb/tb_zx_dcmi_capture.sv
// -----------------------------------------------------------------------------
// tb_zx_dcmi_capture
//
// Directed sequence of frames with random pixel data. Frames are built from a
// fixed geometry (vs cycle, R rows of L pixel cycles plus an hs cycle, then a
// gap), so every pixel's window position is known from the loop indices. Words
// expected per row are derived from the window contents and compared, with
// their arrival cycle, against the words collected from the DUT.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_zx_dcmi_capture;

    localparam int PIX_W = 4;
    localparam int OUT_W = 8;
    localparam int CNT_W = 10;
    localparam int FRM_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [PIX_W-1:0] zx_pix;
    logic             zx_hs;
    logic             zx_vs;
    logic             cfg_enable;
    logic             cfg_pack;
    logic [3:0]       cfg_decim;
    logic [CNT_W-1:0] cfg_x0;
    logic [CNT_W-1:0] cfg_x1;
    logic [CNT_W-1:0] cfg_y0;
    logic [CNT_W-1:0] cfg_y1;
    logic [OUT_W-1:0] dcmi_data;
    logic             dcmi_valid;
    logic             dcmi_href;
    logic             dcmi_vsync;
    logic [FRM_W-1:0] frame_cnt;
    logic [CNT_W-1:0] lines_last;

    always #5 clk = ~clk;

    zx_dcmi_capture #(
        .PIX_W(PIX_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .FRM_W(FRM_W)
    ) dut (
        .ZX_PIX_CLK(clk),
        .reset(reset),
        .zx_pix(zx_pix),
        .zx_hs(zx_hs),
        .zx_vs(zx_vs),
        .cfg_enable(cfg_enable),
        .cfg_pack(cfg_pack),
        .cfg_decim(cfg_decim),
        .cfg_x0(cfg_x0),
        .cfg_x1(cfg_x1),
        .cfg_y0(cfg_y0),
        .cfg_y1(cfg_y1),
        .dcmi_data(dcmi_data),
        .dcmi_valid(dcmi_valid),
        .dcmi_href(dcmi_href),
        .dcmi_vsync(dcmi_vsync),
        .frame_cnt(frame_cnt),
        .lines_last(lines_last)
    );

    typedef struct {
        int d;
        int e;
    } word_t;

    word_t exp_q[$];
    word_t obs_q[$];
    word_t row_q[$];
    int    exp_rd = 0;
    int    obs_rd = 0;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    int href_obs = 0;
    int vs_obs   = 0;
    int href_base = 0;
    int vs_base   = 0;
    int href_exp = 0;
    int vs_exp   = 0;

    // Reference state: frame-level view of what the capture block should do.
    bit m_synced, m_en, m_cap, m_pack;
    int m_x0, m_x1, m_y0, m_y1;
    int m_skip, m_rows, m_lines, m_frames;
    bit ramp_mode;

    // Output collector, sampled mid-cycle.
    always @(negedge clk) begin
        if (dcmi_valid === 1'b1) obs_q.push_back('{int'(dcmi_data), edge_n});
        if (dcmi_href === 1'b1) href_obs++;
        if (dcmi_vsync === 1'b1) vs_obs++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One pixel clock at window position (x, y).
    task automatic step(input bit hs, input bit vs, input int x, input int y);
        logic [3:0] pix;
        bit         act;
        pix = ramp_mode ? 4'((x + 7) % 16) : 4'($urandom);
        zx_pix = pix;
        zx_hs  = hs;
        zx_vs  = vs;
        @(posedge clk);
        edge_n++;
        act = m_synced && m_en && m_cap && (cfg_enable === 1'b1) && y >= m_y0 && y < m_y1;
        if (act && x >= m_x0 && x < m_x1) row_q.push_back('{int'(pix), edge_n});
        if (act) vs_exp++;
        if (hs && !vs) m_rows++;
        if (vs) begin
            m_lines  = m_rows;
            m_rows   = 0;
            m_frames = (m_frames + 1) % 65536;
            m_synced = 1;
            m_en     = cfg_enable;
            m_pack   = cfg_pack;
            m_x0     = int'(cfg_x0);
            m_x1     = int'(cfg_x1);
            m_y0     = int'(cfg_y0);
            m_y1     = int'(cfg_y1);
            m_cap    = (m_skip == 0);
            m_skip   = m_cap ? int'(cfg_decim) : m_skip - 1;
        end
        #1;
    endtask

    // Turn one row's window pixels into expected words.
    task automatic end_row();
        int n;
        n = row_q.size();
        if (!m_pack) begin
            foreach (row_q[i]) exp_q.push_back(row_q[i]);
            href_exp += n;
        end else begin
            for (int i = 0; i + 1 < n; i += 2)
                exp_q.push_back('{(row_q[i+1].d << 4) | row_q[i].d, row_q[i+1].e});
            if (n % 2 == 1) exp_q.push_back('{row_q[n-1].d, row_q[n-1].e + 1});
            href_exp += n + (n % 2);
        end
        row_q.delete();
    endtask

    task automatic verify(input string tag, output int n_obs);
        int n_exp;
        @(negedge clk);
        #1;
        n_obs = obs_q.size() - obs_rd;
        n_exp = exp_q.size() - exp_rd;
        chk({tag, " words"}, n_obs, n_exp);
        for (int i = 0; i < n_obs && i < n_exp; i++) begin
            chk($sformatf("%s word%0d data", tag, i), obs_q[obs_rd+i].d, exp_q[exp_rd+i].d);
            chk($sformatf("%s word%0d cycle", tag, i), obs_q[obs_rd+i].e, exp_q[exp_rd+i].e);
        end
        obs_rd += n_obs;
        exp_rd += n_exp;
        chk({tag, " href cycles"}, href_obs - href_base, href_exp);
        chk({tag, " vsync cycles"}, vs_obs - vs_base, vs_exp);
        href_base = href_obs;
        vs_base   = vs_obs;
        href_exp  = 0;
        vs_exp    = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        zx_hs = 1'b0;
        zx_vs = 1'b0;
        @(posedge clk);
        edge_n++;
        m_synced = 0; m_en = 0; m_cap = 0; m_pack = 0;
        m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
        m_skip = 0; m_rows = 0; m_lines = 0; m_frames = 0;
        row_q.delete();
        #1;
        chk("reset data", dcmi_data, 0);
        chk("reset valid", dcmi_valid, 0);
        chk("reset href", dcmi_href, 0);
        chk("reset vsync", dcmi_vsync, 0);
        chk("reset frame_cnt", frame_cnt, 0);
        chk("reset lines_last", lines_last, 0);
        reset = 1'b1;
    endtask

    // hk_kind: 1 = move cfg_x0 to 20, 2 = drop cfg_enable, 3 = probe vsync.
    task automatic run_frame(input string tag, input int rows, input int len, input int gap,
                             input bit coinc, input int hk_kind, input int hk_row,
                             input int hk_x, output int n_words);
        step(coinc, 1'b1, 0, 9999);
        chk({tag, " frame_cnt"}, frame_cnt, m_frames);
        chk({tag, " lines_last"}, lines_last, m_lines);
        for (int r = 0; r < rows; r++) begin
            for (int x = 0; x <= len; x++) begin
                bit hook;
                hook = (hk_kind != 0) && (r == hk_row) && (x == hk_x);
                if (hook && hk_kind == 1) cfg_x0 = 10'd20;
                if (hook && hk_kind == 2) cfg_enable = 1'b0;
                step(x == len, 1'b0, x, r);
                if (hook && hk_kind == 2) begin
                    chk({tag, " valid after disable"}, dcmi_valid, 0);
                    chk({tag, " href after disable"}, dcmi_href, 0);
                    chk({tag, " vsync after disable"}, dcmi_vsync, 0);
                end
                if (hook && hk_kind == 3) chk({tag, " vsync row0"}, dcmi_vsync, 1);
            end
            end_row();
        end
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, g, rows);
        end_row();
        verify(tag, n_words);
    endtask

    initial begin
        int n;
        int base;
        reset = 1'b0; zx_pix = '0; zx_hs = 1'b0; zx_vs = 1'b0;
        cfg_enable = 1'b1; cfg_pack = 1'b0; cfg_decim = 4'd0;
        cfg_x0 = 10'd0; cfg_x1 = 10'd4; cfg_y0 = 10'd0; cfg_y1 = 10'd1;
        ramp_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Nothing may come out before the first frame start.
        for (int x = 0; x < 10; x++) step(1'b0, 1'b0, x, 0);
        verify("pre_vs", n);
        chk("pre_vs none", n, 0);

        // Unpacked, window (0,4)x(0,1), 312-line frame.
        run_frame("t1f1", 312, 5, 3, 0, 0, 0, 0, n);
        chk("t1 words", n, 4);
        run_frame("t1f2", 2, 5, 3, 0, 0, 0, 0, n);
        chk("t1 lines_last", lines_last, 312);
        chk("t1 frame_cnt", frame_cnt, 2);

        // Packed, x [10,15), pixels 1..5.
        cfg_pack = 1'b1; cfg_x0 = 10'd10; cfg_x1 = 10'd15; ramp_mode = 1;
        base = obs_q.size();
        run_frame("t2", 2, 16, 3, 0, 0, 0, 0, n);
        chk("t2 words", n, 3);
        if (obs_q.size() >= base + 3) begin
            chk("t2 word0", obs_q[base].d, 'h21);
            chk("t2 word1", obs_q[base+1].d, 'h43);
            chk("t2 flush", obs_q[base+2].d, 'h05);
            chk("t2 flush gap", obs_q[base+2].e - obs_q[base+1].e, 2);
        end
        cfg_pack = 1'b0; ramp_mode = 0;

        // Mid-frame x0 change applies from the next frame.
        cfg_x0 = 10'd10; cfg_x1 = 10'd25; cfg_y1 = 10'd2;
        run_frame("t4a", 4, 30, 3, 0, 1, 1, 0, n);
        chk("t4a words", n, 30);
        run_frame("t4b", 4, 30, 3, 0, 0, 0, 0, n);
        chk("t4b words", n, 10);

        // Live enable drop mid-line.
        cfg_x0 = 10'd0; cfg_x1 = 10'd10;
        run_frame("t5a", 2, 12, 3, 0, 2, 0, 5, n);
        chk("t5a words", n, 5);
        run_frame("t5b", 2, 12, 3, 0, 0, 0, 0, n);
        chk("t5b words", n, 0);
        cfg_enable = 1'b1;

        // Decimation 2: frames 1, 4, 7 captured.
        do_reset();
        cfg_decim = 4'd2; cfg_x0 = 10'd0; cfg_x1 = 10'd4; cfg_y1 = 10'd1;
        for (int fi = 1; fi <= 7; fi++) begin
            run_frame($sformatf("t3f%0d", fi), 2, 5, 3, 0, 0, 0, 0, n);
            chk($sformatf("t3f%0d active", fi), n > 0, (fi % 3) == 1);
        end

        // Reset mid-window, then inverted window with coincident hs/vs.
        do_reset();
        cfg_decim = 4'd0; cfg_x0 = 10'd0; cfg_x1 = 10'd10; cfg_y1 = 10'd2;
        step(1'b0, 1'b1, 0, 9999);
        for (int x = 0; x < 6; x++) step(1'b0, 1'b0, x, 0);
        end_row();
        do_reset();
        verify("t6 pre", n);
        chk("t6 pre words", n, 6);
        cfg_x0 = 10'd8; cfg_x1 = 10'd5; cfg_y1 = 10'd1;
        run_frame("t6c", 3, 10, 3, 1, 3, 0, 2, n);
        chk("t6c words", n, 0);
        run_frame("t6d", 2, 10, 3, 0, 0, 0, 0, n);
        chk("t6d words", n, 0);
        chk("t6 lines_last", lines_last, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
